i2c_mem_arbiter: RTL and testbench
==================================

Name: i2c_mem_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one i2c_mem instance between NREQ requesters.
- The memory free-runs: it restarts a transaction every time it returns to idle, sampling wr/addr/din. This block therefore owns mem_wr/mem_addr/mem_din and changes them only on the mem_done cycle.
- It returns read data and completion strobes to each requester and fills unused slots with harmless dummy reads.
- It sits between client logic and the i2c_mem, one level up in the memory subsystem.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 7, memory address width
- DW, 8, data width
- TIMEOUT, 256, max cycles between mem_done pulses before the slot is aborted

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester request; held high until that requester's rsp_valid
- req_wr  in  NREQ  1=write, 0=read; stable while req high
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_din  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot; owner of the transaction currently in flight
- rsp_valid  out  NREQ  one-cycle completion pulse to the owner
- rsp_err  out  1  qualifies rsp_valid: 1 = aborted by timeout
- rsp_data  out  DW  read data, valid with rsp_valid
- mem_wr  out  1  to i2c_mem wr
- mem_addr  out  AW  to i2c_mem addr
- mem_din  out  DW  to i2c_mem din
- mem_datard  in  DW  from i2c_mem datard
- mem_done  in  1  from i2c_mem done
- busy  out  1  high while gnt is nonzero

Behaviour:
- Reset (rst high at posedge):
  - gnt=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0
  - mem_wr=0, mem_addr=0, mem_din=0
  - rr pointer=0, watchdog=0, state=SYNC
- States: SYNC, DUMMY, ACTIVE.
  - SYNC: the in-flight memory transaction is unknown. Drive the dummy read (wr=0, addr=0, din=0) and ignore req. On mem_done, arbitrate.
  - DUMMY: a dummy read is in flight. On mem_done, discard mem_datard, no rsp_valid, then arbitrate.
  - ACTIVE: a granted transaction is in flight. On mem_done, pulse rsp_valid[owner] for 1 cycle with rsp_err=0.
    - rsp_data = mem_datard if the owner read, 0 if it wrote.
    - Then arbitrate in the same cycle.
- Arbitration happens only on a mem_done cycle:
  - Candidates are req & ~mask, where mask = one-hot of the owner completing this cycle. This prevents a stale re-grant, because the requester drops req one cycle after rsp_valid.
  - Search order starts at (last owner + 1) mod NREQ, i.e. round-robin.
  - On a winner k: register gnt=1<<k, mem_wr=req_wr[k], mem_addr=req_addr[k], mem_din=req_din[k]; next state ACTIVE; pointer=k.
  - On no winner: gnt=0, dummy read values; next state DUMMY.
- mem_* outputs are registered and change only on the edge where mem_done=1. They are stable for the whole transaction, including wr, which the memory re-reads at ack time.
- Latency:
  - A request raised while idle is granted at the next mem_done (at most one dummy transaction later).
  - rsp_valid comes at the mem_done that ends the granted transaction.
- Watchdog:
  - Counts cycles since the last mem_done (or reset) and clears on mem_done.
  - When it reaches TIMEOUT: if ACTIVE, pulse rsp_valid[owner] with rsp_err=1 and rsp_data=0.
  - In any state: gnt=0, drive dummy values, state=SYNC, watchdog=0.
- Simultaneous requests: exactly one grant per transaction. No requester waits more than NREQ-1 transactions while continuously requesting.
- Dropping req while granted has no effect on the in-flight transaction; the response is still pulsed.
- rsp_valid is never asserted for more than one requester or more than one cycle.
- rst mid-transaction returns to SYNC. The first mem_done after reset never produces rsp_valid.

Test Plan:
- Reset, no requests, memory model pulsing done every 40 cycles → only dummy reads at addr 0, rsp_valid never asserted, gnt=0.
- Requester 1 writes addr 0x15 data 0xA5, then reads addr 0x15 → write rsp_valid with rsp_data=0; read rsp_valid with rsp_data=0xA5; mem_addr=0x15 held constant between the bounding mem_done pulses.
- All four requesters request together from reset → grant order 0,1,2,3, one rsp_valid each, no overlap; requester 0 requests again immediately and is granted after 3.
- Only requester 2 requests continuously → grants alternate ACTIVE/DUMMY because of the completion mask, with no back-to-back duplicate grant.
- Memory stalls with no mem_done for TIMEOUT=256 cycles while requester 3 is granted → rsp_valid[3]=1, rsp_err=1, rsp_data=0, state=SYNC; the next mem_done re-arbitrates normally.
- rst asserted mid-ACTIVE → all outputs return to reset values next cycle; the first subsequent mem_done gives no rsp_valid.

Source files
------------

// File: rtl/i2c_mem_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one free-running
// i2c_mem between NREQ requesters. Memory-side outputs change only on the
// mem_done edge (or on watchdog/reset recovery); idle slots carry dummy reads.
module i2c_mem_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 7,
  parameter int DW      = 8,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_err,
  output logic [DW-1:0]     rsp_data,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_datard,
  input  logic              mem_done,
  output logic              busy
);

  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {SYNC, DUMMY, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic              mem_wr_q, mem_wr_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_din_q, mem_din_d;
  // Holds the first index to search, i.e. one past the last owner; the
  // reset value 0 makes requester 0 first in line after reset.
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [WW-1:0]     wdog_q, wdog_d;

  logic [NREQ-1:0]   cand;
  logic              found;
  logic [PW-1:0]     win;
  int unsigned       idx;

  // Round-robin search over requesters, excluding the owner completing now
  always_comb begin
    cand  = req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Next-state, response and memory-command logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    ptr_d       = ptr_q;
    wdog_d      = wdog_q + 1'b1;

    if (mem_done) begin
      wdog_d = '0;
      if (state_q == ACTIVE) begin
        rsp_valid_d = gnt_q;
        rsp_data_d  = mem_wr_q ? '0 : mem_datard;
      end
      if (found) begin
        gnt_d      = NREQ'(1) << win;
        mem_wr_d   = req_wr[win];
        mem_addr_d = req_addr[int'(win)*AW +: AW];
        mem_din_d  = req_din[int'(win)*DW +: DW];
        ptr_d      = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        state_d    = ACTIVE;
      end else begin
        gnt_d      = '0;
        mem_wr_d   = 1'b0;
        mem_addr_d = '0;
        mem_din_d  = '0;
        state_d    = DUMMY;
      end
    end else if (wdog_q == WW'(TIMEOUT - 1)) begin
      if (state_q == ACTIVE) begin
        rsp_valid_d = gnt_q;
        rsp_err_d   = 1'b1;
        rsp_data_d  = '0;
      end
      gnt_d      = '0;
      mem_wr_d   = 1'b0;
      mem_addr_d = '0;
      mem_din_d  = '0;
      state_d    = SYNC;
      wdog_d     = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      ptr_q       <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      ptr_q       <= ptr_d;
      wdog_q      <= wdog_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign busy      = |gnt_q;

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Bench for i2c_mem_arbiter: free-running memory model, requester agents and
// a transaction-level reference model checked every cycle.
module tb_i2c_mem_arbiter;

  localparam int NREQ = 4, AW = 7, DW = 8, TIMEOUT = 256;

  logic               clk, rst;
  logic [NREQ-1:0]    req, req_wr;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]    gnt, rsp_valid;
  logic               rsp_err, mem_wr, mem_done, busy;
  logic [DW-1:0]      rsp_data, mem_din, mem_datard;
  logic [AW-1:0]      mem_addr;

  i2c_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_din(req_din), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_datard(mem_datard), .mem_done(mem_done), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0, checks = 0;

  // memory model
  logic [DW-1:0] mem_arr [2**AW];
  int mcnt = 0, period = 40;
  bit stall = 0, rand_period = 0;

  // reference model (transaction level: who owns the memory slot)
  int m_owner, m_last, m_idle;
  bit m_own_wr;
  logic [NREQ-1:0] exp_gnt, exp_rv;
  logic            exp_err, exp_wr, exp_rd_chk;
  logic [DW-1:0]   exp_data, exp_din;
  logic [AW-1:0]   exp_addr;

  // requester agents: mode 0 manual, 1 re-request after one idle cycle, 2 random
  int mode [NREQ];
  bit cool [NREQ];
  int rsp_cnt [NREQ];
  logic [DW-1:0] last_data [NREQ];
  bit last_err [NREQ];
  int total_rsp = 0;
  int glog [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic mem_drive();
    mem_datard = DW'($urandom);
    mem_done   = 1'b0;
    if (rst) mcnt = 0;
    else if (!stall) begin
      mcnt++;
      if (mcnt >= period) begin
        mcnt = 0;
        mem_done = 1'b1;
        if (mem_wr) mem_arr[mem_addr] = mem_din;
        else mem_datard = mem_arr[mem_addr];
        if (rand_period) period = int'($urandom_range(3, 12));
      end
    end
  endtask

  task automatic model_dummy();
    m_owner = -1;
    exp_wr = 1'b0; exp_addr = '0; exp_din = '0;
  endtask

  task automatic model_step();
    int win;
    exp_rv = '0;
    exp_err = 1'b0;
    if (rst) begin
      model_dummy();
      m_last = NREQ - 1;
      m_idle = 0;
      exp_data = '0;
    end else if (mem_done) begin
      if (m_owner >= 0) begin
        exp_rv   = NREQ'(1) << m_owner;
        exp_data = m_own_wr ? '0 : mem_datard;
      end
      win = -1;
      for (int j = 1; j <= NREQ; j++) begin
        int k = (m_last + j) % NREQ;
        if (win < 0 && req[k] && k != m_owner) win = k;
      end
      if (win >= 0) begin
        m_owner  = win;
        m_last   = win;
        m_own_wr = req_wr[win];
        exp_wr   = req_wr[win];
        exp_addr = req_addr[win*AW +: AW];
        exp_din  = req_din[win*DW +: DW];
      end else model_dummy();
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        if (m_owner >= 0) begin
          exp_rv   = NREQ'(1) << m_owner;
          exp_err  = 1'b1;
          exp_data = '0;
        end
        model_dummy();
        m_idle = 0;
      end
    end
    exp_gnt    = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    exp_rd_chk = rst || (exp_rv != '0);
  endtask

  task automatic check_outputs();
    chk("gnt", gnt, exp_gnt);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_err", rsp_err, exp_err);
    if (exp_rd_chk) chk("rsp_data", rsp_data, exp_data);
    chk("mem_wr", mem_wr, exp_wr);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_din", mem_din, exp_din);
    chk("busy", busy, exp_gnt != '0);
  endtask

  task automatic agents_update();
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i]) begin
        req[i] = 1'b0;
        cool[i] = 1'b1;
        rsp_cnt[i]++;
        total_rsp++;
        last_data[i] = rsp_data;
        last_err[i] = rsp_err;
      end else if (cool[i]) begin
        cool[i] = 1'b0;
        if (mode[i] == 1) req[i] = 1'b1;
      end else if (mode[i] == 2 && !req[i] && $urandom_range(0, 3) == 0) begin
        req_wr[i] = 1'($urandom_range(0, 1));
        req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        req_din[i*DW +: DW] = DW'($urandom);
        req[i] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    bit dn;
    mem_drive();
    model_step();
    dn = mem_done && !rst;
    @(negedge clk);
    check_outputs();
    if (dn) glog.push_back(oh_idx(gnt));
    agents_update();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((req != '0 || gnt != '0) && n < 2000) begin cycle(); n++; end
    chk(tag, {req, gnt}, '0);
  endtask

  task automatic wait_gnt(input int i);
    int n = 0;
    while (!gnt[i] && n < 500) begin cycle(); n++; end
    chk($sformatf("gnt_seen%0d", i), gnt[i], 1'b1);
  endtask

  task automatic issue(input int i, input bit wr, input int addr, input int din,
                       output logic [DW-1:0] data);
    int start = rsp_cnt[i];
    int n = 0, bad = 0;
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = AW'(addr);
    req_din[i*DW +: DW] = DW'(din);
    req[i] = 1'b1;
    while (rsp_cnt[i] == start && n < 2000) begin
      cycle();
      n++;
      if (gnt[i] && mem_addr != AW'(addr)) bad++;
    end
    chk($sformatf("rsp_arrived%0d", i), rsp_cnt[i] - start, 1);
    chk($sformatf("addr_hold%0d", i), bad, 0);
    data = last_data[i];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [DW-1:0] d;
    int n, s, dup, cnt2;
    int ng [$];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    for (int a = 0; a < 2**AW; a++) mem_arr[a] = '0;
    for (int i = 0; i < NREQ; i++) begin
      mode[i] = 0; cool[i] = 0; rsp_cnt[i] = 0; last_data[i] = '0; last_err[i] = 0;
    end
    rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_din = '0;
    mem_done = 1'b0; mem_datard = '0;
    run(3);
    rst = 1'b0;

    // idle: only dummy reads
    glog.delete();
    run(200);
    chk("idle_rsp_count", total_rsp, 0);
    n = 0;
    foreach (glog[j]) if (glog[j] != -1) n++;
    chk("idle_grants", n, 0);
    chk("idle_dones", glog.size() >= 4, 1);

    // write then read back through requester 1
    issue(1, 1'b1, 'h15, 'hA5, d);
    chk("write_rsp_data", d, 8'h00);
    issue(1, 1'b0, 'h15, 'h00, d);
    chk("read_rsp_data", d, 8'hA5);

    // all four from reset, requester 0 re-requests immediately
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    glog.delete();
    for (int i = 0; i < NREQ; i++) begin
      req_wr[i] = 1'b0;
      req_addr[i*AW +: AW] = AW'(i);
      rsp_cnt[i] = 0;
    end
    req = '1;
    mode[0] = 1;
    n = 0;
    ng.delete();
    while (ng.size() < 5 && n < 2000) begin
      cycle();
      n++;
      ng.delete();
      foreach (glog[j]) if (glog[j] >= 0) ng.push_back(glog[j]);
    end
    chk("order_len", ng.size(), 5);
    for (int j = 0; j < 5 && j < ng.size(); j++)
      chk($sformatf("order%0d", j), ng[j], exp_order[j]);
    chk("rsp_once1", rsp_cnt[1], 1);
    chk("rsp_once2", rsp_cnt[2], 1);
    chk("rsp_once3", rsp_cnt[3], 1);
    mode[0] = 0;
    drain("drain_all4");

    // single continuous requester alternates with dummy slots
    glog.delete();
    req_wr[2] = 1'b0;
    mode[2] = 1;
    req[2] = 1'b1;
    n = 0;
    while (glog.size() < 8 && n < 2000) begin cycle(); n++; end
    dup = 0; cnt2 = 0;
    foreach (glog[j]) begin
      if (glog[j] == 2) cnt2++;
      if (j > 0 && glog[j] == 2 && glog[j-1] == 2) dup++;
    end
    chk("no_dup_grant", dup, 0);
    chk("req2_grants", cnt2 >= 3, 1);
    mode[2] = 0;
    drain("drain_req2");

    // watchdog abort while requester 3 is granted
    req_wr[3] = 1'b1;
    req_addr[3*AW +: AW] = AW'('h33);
    req_din[3*DW +: DW] = 8'h5C;
    req[3] = 1'b1;
    wait_gnt(3);
    stall = 1;
    s = rsp_cnt[3];
    n = 0;
    while (rsp_cnt[3] == s && n < TIMEOUT + 20) begin cycle(); n++; end
    chk("wdog_rsp", rsp_cnt[3] - s, 1);
    chk("wdog_err", last_err[3], 1'b1);
    chk("wdog_data", last_data[3], 8'h00);
    stall = 0;
    glog.delete();
    s = total_rsp;
    n = 0;
    while (glog.size() < 1 && n < 200) begin cycle(); n++; end
    chk("wdog_rearb", glog.size() >= 1 ? glog[0] : -2, -1);
    chk("wdog_no_rsp", total_rsp - s, 0);

    // reset in the middle of an active read
    req_wr[0] = 1'b0;
    req_addr[0 +: AW] = AW'('h15);
    req[0] = 1'b1;
    s = rsp_cnt[0];
    wait_gnt(0);
    run(5);
    rst = 1'b1;
    cycle();
    chk("rst_gnt", gnt, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    rst = 1'b0;
    glog.delete();
    s = total_rsp;
    n = 0;
    while (glog.size() < 1 && n < 200) begin cycle(); n++; end
    chk("first_done_no_rsp", total_rsp - s, 0);
    s = rsp_cnt[0];
    n = 0;
    while (rsp_cnt[0] == s && n < 200) begin cycle(); n++; end
    chk("post_rst_read", last_data[0], 8'hA5);

    // randomized traffic with varying memory latency
    rand_period = 1;
    period = 5;
    for (int i = 0; i < NREQ; i++) mode[i] = 2;
    run(3000);
    for (int i = 0; i < NREQ; i++) mode[i] = 0;
    drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
